// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: address map, access-size encodings, lane merge helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

  // Data memory occupies the bottom of the map; the size is a top-level parameter.
  localparam logic [15:0] DMEM_BASE      = 16'h0000;
  localparam int          DMEM_MAX_BYTES = 16384;

  // Output peripheral registers.
  localparam logic [15:0] ADDR_LEDR  = 16'h7000;
  localparam logic [15:0] ADDR_LEDG  = 16'h7010;
  localparam logic [15:0] ADDR_HEX_L = 16'h7020;
  localparam logic [15:0] ADDR_HEX_H = 16'h7024;
  localparam logic [15:0] ADDR_LCD   = 16'h7030;

  // Input ports.
  localparam logic [15:0] ADDR_SW    = 16'h7800;
  localparam logic [15:0] ADDR_KEY   = 16'h7810;

  // Access size/sign, RISC-V funct3 encoding.
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // Replace the byte lanes of old_word selected by be with the lanes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-lane-enabled word memory: asynchronous read, synchronous byte-masked write; contents not reset.
// Latency: read 0 cycles (combinational), write visible after the next rising edge.
// Backpressure: none, accepts a write every cycle.
// Ports: clk; i_wr_en/i_be/i_idx/i_wdata write side; o_rdata reads word i_idx.
module lsu_dmem #(
  parameter int WORDS = 512,
  localparam int IW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [3:0]    i_be,
  input  logic [IW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes a 16-bit byte address onto DMEM, output registers and input ports.
// Latency: loads combinational (0 cycles); stores take effect on the next rising edge.
// Backpressure: none, one access per cycle; unmapped/read-only stores are dropped.
// Ports: clk, rst_n (async, active-low); addr/w_en/w_data/data_mode access request;
//        r_data load result; SW/KEY live inputs; LEDR/LEDG/HEX_H/HEX_L/LCD output registers.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        w_en,
  input  logic [31:0] w_data,
  input  logic [2:0]  data_mode,
  output logic [31:0] r_data,
  input  logic [31:0] SW,
  input  logic [31:0] KEY,
  output logic [31:0] LEDR,
  output logic [31:0] LEDG,
  output logic [31:0] HEX_H,
  output logic [31:0] HEX_L,
  output logic [31:0] LCD
);

  localparam int AW    = $clog2(DMEM_BYTES);
  localparam int WORDS = DMEM_BYTES / 4;

  // Address decode: DMEM by upper-bit range check, peripherals by word address.
  logic w_dmem_hit;
  logic w_sel_ledr, w_sel_ledg, w_sel_hexl, w_sel_hexh, w_sel_lcd, w_sel_sw, w_sel_key;

  assign w_dmem_hit = (addr[15:AW] == DMEM_BASE[15:AW]);
  assign w_sel_ledr = (addr[15:2] == ADDR_LEDR[15:2]);
  assign w_sel_ledg = (addr[15:2] == ADDR_LEDG[15:2]);
  assign w_sel_hexl = (addr[15:2] == ADDR_HEX_L[15:2]);
  assign w_sel_hexh = (addr[15:2] == ADDR_HEX_H[15:2]);
  assign w_sel_lcd  = (addr[15:2] == ADDR_LCD[15:2]);
  assign w_sel_sw   = (addr[15:2] == ADDR_SW[15:2]);
  assign w_sel_key  = (addr[15:2] == ADDR_KEY[15:2]);

  // Byte enables and lane-replicated store data; modes 011/11x store as a word.
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = w_data;
    case (data_mode[1:0])
      2'b00: begin
        w_be        = 4'b0001 << addr[1:0];
        w_wdata_rep = {4{w_data[7:0]}};
      end
      2'b01: begin
        w_be        = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{w_data[15:0]}};
      end
      default: ;
    endcase
  end

  // DMEM writes are masked while reset is held; the array itself is never cleared.
  logic [31:0] w_dmem_rdata;

  lsu_dmem #(.WORDS(WORDS)) u_dmem (
    .clk     (clk),
    .i_wr_en (w_en & rst_n & w_dmem_hit),
    .i_be    (w_be),
    .i_idx   (addr[AW-1:2]),
    .i_wdata (w_wdata_rep),
    .o_rdata (w_dmem_rdata)
  );

  // Output peripheral registers.
  logic [31:0] r_ledr, r_ledg, r_hexl, r_hexh, r_lcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_hexl <= '0;
      r_hexh <= '0;
      r_lcd  <= '0;
    end else if (w_en) begin
      if (w_sel_ledr) r_ledr <= merge_bytes(r_ledr, w_wdata_rep, w_be);
      if (w_sel_ledg) r_ledg <= merge_bytes(r_ledg, w_wdata_rep, w_be);
      if (w_sel_hexl) r_hexl <= merge_bytes(r_hexl, w_wdata_rep, w_be);
      if (w_sel_hexh) r_hexh <= merge_bytes(r_hexh, w_wdata_rep, w_be);
      if (w_sel_lcd)  r_lcd  <= merge_bytes(r_lcd,  w_wdata_rep, w_be);
    end
  end

  assign LEDR  = r_ledr;
  assign LEDG  = r_ledg;
  assign HEX_L = r_hexl;
  assign HEX_H = r_hexh;
  assign LCD   = r_lcd;

  // Raw word selection; unmapped addresses read as zero.
  logic [31:0] w_raw;

  always_comb begin
    w_raw = '0;
    if      (w_dmem_hit) w_raw = w_dmem_rdata;
    else if (w_sel_ledr) w_raw = r_ledr;
    else if (w_sel_ledg) w_raw = r_ledg;
    else if (w_sel_hexl) w_raw = r_hexl;
    else if (w_sel_hexh) w_raw = r_hexh;
    else if (w_sel_lcd)  w_raw = r_lcd;
    else if (w_sel_sw)   w_raw = SW;
    else if (w_sel_key)  w_raw = KEY;
  end

  // Lane extraction and sign/zero extension.
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = w_raw[7:0];
    case (addr[1:0])
      2'b01:   w_byte = w_raw[15:8];
      2'b10:   w_byte = w_raw[23:16];
      2'b11:   w_byte = w_raw[31:24];
      default: w_byte = w_raw[7:0];
    endcase
  end

  assign w_half = addr[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    r_data = w_raw;
    case (data_mode)
      MODE_B:  r_data = {{24{w_byte[7]}}, w_byte};
      MODE_H:  r_data = {{16{w_half[15]}}, w_half};
      MODE_BU: r_data = {24'h0, w_byte};
      MODE_HU: r_data = {16'h0, w_half};
      default: r_data = w_raw;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: map decode, stores, sub-word loads, discards and asynchronous reset.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        w_en;
  logic [31:0] w_data;
  logic [2:0]  data_mode;
  logic [31:0] r_data;
  logic [31:0] SW, KEY;
  logic [31:0] LEDR, LEDG, HEX_H, HEX_L, LCD;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sweep_val [512];
  logic [31:0] v_ledg, v_hexl, v_hexh, v_lcd, rd;
  logic [31:0] s_ledr, s_ledg, s_hexl, s_hexh, s_lcd, s_w0, s_w10;

  lsu #(.DMEM_BYTES(2048)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .w_en      (w_en),
    .w_data    (w_data),
    .data_mode (data_mode),
    .r_data    (r_data),
    .SW        (SW),
    .KEY       (KEY),
    .LEDR      (LEDR),
    .LEDG      (LEDG),
    .HEX_H     (HEX_H),
    .HEX_L     (HEX_L),
    .LCD       (LCD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Store presented after a falling edge, committed at the following rising edge.
  task automatic st(input logic [15:0] a, input logic [31:0] d, input logic [2:0] m);
    @(negedge clk);
    addr = a; w_data = d; data_mode = m; w_en = 1'b1;
    @(posedge clk);
    #1;
    w_en = 1'b0;
  endtask

  task automatic ld(input logic [15:0] a, input logic [2:0] m, output logic [31:0] d);
    w_en = 1'b0; addr = a; data_mode = m;
    #1;
    d = r_data;
  endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; addr = '0; w_data = '0; data_mode = 3'b010;
    SW = 32'hA5A5_1234; KEY = 32'h0000_000E;

    // Reset state of all output registers.
    #1;
    chk("rst_ledr", LEDR, 32'h0);
    chk("rst_ledg", LEDG, 32'h0);
    chk("rst_hexl", HEX_L, 32'h0);
    chk("rst_hexh", HEX_H, 32'h0);
    chk("rst_lcd",  LCD,  32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Input ports read live.
    ld(16'h7800, 3'b010, rd); chk("ld_sw", rd, 32'hA5A5_1234);
    ld(16'h7810, 3'b010, rd); chk("ld_key", rd, 32'h0000_000E);
    SW = 32'h0F0F_0001;
    ld(16'h7800, 3'b010, rd); chk("ld_sw_live", rd, 32'h0F0F_0001);
    SW = 32'hA5A5_1234;

    // LEDR store: output must not move before the edge.
    @(negedge clk);
    addr = 16'h7000; w_data = 32'hDEAD_BEEF; data_mode = 3'b010; w_en = 1'b1;
    #1;
    chk("ledr_pre_edge", LEDR, 32'h0);
    chk("ledr_rd_old", r_data, 32'h0);
    @(posedge clk); #1; w_en = 1'b0;
    chk("ledr_port", LEDR, 32'hDEAD_BEEF);
    ld(16'h7000, 3'b010, rd); chk("ledr_rb", rd, 32'hDEAD_BEEF);

    v_ledg = $urandom; v_hexl = $urandom; v_hexh = $urandom; v_lcd = $urandom;
    st(16'h7010, v_ledg, 3'b010);
    st(16'h7020, v_hexl, 3'b010);
    st(16'h7024, v_hexh, 3'b010);
    st(16'h7033, v_lcd,  3'b010);   // addr[1:0] ignored for W
    chk("ledg_port", LEDG, v_ledg);
    chk("hexl_port", HEX_L, v_hexl);
    chk("hexh_port", HEX_H, v_hexh);
    chk("lcd_port",  LCD,  v_lcd);
    chk("ledr_kept", LEDR, 32'hDEAD_BEEF);
    ld(16'h7010, 3'b010, rd); chk("ledg_rb", rd, v_ledg);
    ld(16'h7020, 3'b010, rd); chk("hexl_rb", rd, v_hexl);
    ld(16'h7024, 3'b010, rd); chk("hexh_rb", rd, v_hexh);
    ld(16'h7030, 3'b010, rd); chk("lcd_rb",  rd, v_lcd);

    // DMEM sweep.
    for (int i = 0; i < 512; i++) begin
      sweep_val[i] = $urandom;
      st(16'(i * 4), sweep_val[i], 3'b010);
    end
    for (int i = 0; i < 512; i++) begin
      ld(16'(i * 4), 3'b010, rd);
      chk($sformatf("sweep_%0d", i), rd, sweep_val[i]);
    end

    // Sub-word accesses; word bytes are 01 F0 70 80 from lane 0 upward.
    st(16'h0010, 32'h8070_F001, 3'b010);
    ld(16'h0011, 3'b000, rd); chk("b_0011",  rd, 32'hFFFF_FFF0);
    ld(16'h0011, 3'b100, rd); chk("bu_0011", rd, 32'h0000_00F0);
    ld(16'h0012, 3'b001, rd); chk("h_0012",  rd, 32'hFFFF_8070);
    ld(16'h0012, 3'b101, rd); chk("hu_0012", rd, 32'h0000_8070);
    ld(16'h0010, 3'b000, rd); chk("b_0010",  rd, 32'h0000_0001);
    ld(16'h0011, 3'b001, rd); chk("h_0011",  rd, 32'hFFFF_F001);
    ld(16'h0012, 3'b011, rd); chk("m011_w",  rd, 32'h8070_F001);
    ld(16'h0010, 3'b111, rd); chk("m111_w",  rd, 32'h8070_F001);
    st(16'h0013, 32'h0000_0055, 3'b000);
    ld(16'h0010, 3'b010, rd); chk("b_store", rd, 32'h5570_F001);
    st(16'h0017, 32'h1234_ABCD, 3'b001);   // half store, addr[0] ignored
    ld(16'h0014, 3'b010, rd); chk("h_store", rd, {16'hABCD, sweep_val[5][15:0]});

    // Same-cycle load of the word being stored returns the old contents.
    @(negedge clk);
    addr = 16'h0010; w_data = 32'h0BAD_F00D; data_mode = 3'b010; w_en = 1'b1;
    #1;
    chk("rw_old", r_data, 32'h5570_F001);
    @(posedge clk); #1; w_en = 1'b0;
    ld(16'h0010, 3'b010, rd); chk("rw_new", rd, 32'h0BAD_F00D);

    // Discarded stores.
    s_ledr = 32'hDEAD_BEEF; s_ledg = v_ledg; s_hexl = v_hexl; s_hexh = v_hexh; s_lcd = v_lcd;
    s_w0 = sweep_val[0]; s_w10 = 32'h0BAD_F00D;
    st(16'h7800, 32'h1111_1111, 3'b010);
    st(16'h4000, 32'h2222_2222, 3'b010);
    chk("dis_ledr", LEDR, s_ledr);
    chk("dis_ledg", LEDG, s_ledg);
    chk("dis_hexl", HEX_L, s_hexl);
    chk("dis_hexh", HEX_H, s_hexh);
    chk("dis_lcd",  LCD,  s_lcd);
    ld(16'h0000, 3'b010, rd); chk("dis_w0",  rd, s_w0);
    ld(16'h0010, 3'b010, rd); chk("dis_w10", rd, s_w10);
    ld(16'h4000, 3'b010, rd); chk("unmap_rd", rd, 32'h0);
    ld(16'h7800, 3'b010, rd); chk("sw_after", rd, 32'hA5A5_1234);
    ld(16'h7004, 3'b010, rd); chk("unmap_7004", rd, 32'h0);

    // Asynchronous reset mid-run.
    st(16'h7010, 32'h0000_1234, 3'b010);
    chk("ledg_1234", LEDG, 32'h0000_1234);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ledg", LEDG, 32'h0);
    chk("arst_ledr", LEDR, 32'h0);
    chk("arst_lcd",  LCD,  32'h0);
    st(16'h7000, 32'hCAFE_0000, 3'b010);   // ignored under reset
    chk("rst_st_ledr", LEDR, 32'h0);
    st(16'h0000, 32'hCAFE_0001, 3'b010);   // ignored under reset
    @(negedge clk); rst_n = 1'b1;
    ld(16'h0010, 3'b010, rd); chk("arst_dmem", rd, 32'h0BAD_F00D);
    ld(16'h0000, 3'b010, rd); chk("rst_st_dmem", rd, s_w0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
